hazard_stall_controller: RTL and testbench
==========================================

HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-specifier width.
REQ-002 SHALL have parameter LOAD_USE_STALLS, default 1, legal 1..3; bubble cycles inserted per load-use hazard.
REQ-003 SHALL have parameter BRANCH_IN_ID, default 1; 1 enables branch-operand hazard detection in ID.
REQ-004 SHALL have parameter CNT_W, default 32, stall-statistics counter width.
REQ-005 SHALL have one clock; reset is asynchronous and active-low: Clock input 1 rising-edge clock; Reset input 1 asynchronous active-low reset.
REQ-006 SHALL have ID_Rs, ID_Rt input REG_ADDR_W; source specifiers of the instruction in ID.
REQ-007 SHALL have ID_UsesRs, ID_UsesRt, ID_IsBranch input 1 each; the ID instruction reads rs / reads rt / is a branch resolved in ID.
REQ-008 SHALL have EX_MemRead, EX_RegWrite input 1; EX_Rd input REG_ADDR_W; destination info of the instruction in EX.
REQ-009 SHALL have MEM_MemRead, MEM_MemWrite, MEM_RegWrite input 1; MEM_Rd input REG_ADDR_W; DMem_Ready input 1, data memory has completed the access.
REQ-010 SHALL have PC_WriteEnable, IFID_WriteEnable output 1; Flush output 1, zeroes ID/EX control; Freeze output 1, holds ID/EX, EX/MEM and MEM/WB; StallCycles output CNT_W.

Function
REQ-011 A match SHALL require the compared specifier to be nonzero, the use flag set, and equality; register 0 never hazards.
REQ-012 Load-use hazard: EX_MemRead & EX_RegWrite & match(EX_Rd); stall length = LOAD_USE_STALLS.
REQ-013 Branch hazard (BRANCH_IN_ID=1 only): ID_IsBranch & EX_RegWrite & match(EX_Rd) gives length 1, or 2 if EX_MemRead is also set; else ID_IsBranch & MEM_MemRead & MEM_RegWrite & match(MEM_Rd) gives length 1; the maximum applicable length wins.
REQ-014 Memory wait: (MEM_MemRead | MEM_MemWrite) & ~DMem_Ready.
REQ-015 FSM states SHALL be RUN, STALL, FREEZE; state, 2-bit counter and 1-bit return-state register are updated on rising Clock.
REQ-016 RUN with no hazard: PC_WriteEnable=1, IFID_WriteEnable=1, Flush=0, Freeze=0.
REQ-017 RUN with hazard of length L and no memory wait:
  - same cycle (combinational): PC_WriteEnable=0, IFID_WriteEnable=0, Flush=1;
  - if L>1: next state STALL, counter=L-2;
  - if L=1: remain RUN.
REQ-018 STALL: outputs as REQ-017 regardless of hazard inputs; counter decrements each cycle; at counter=0 next state is RUN.
REQ-019 A memory wait in any state SHALL take priority:
  - Freeze=1, PC_WriteEnable=0, IFID_WriteEnable=0, Flush=0;
  - counter holds;
  - from RUN/STALL, the current state is saved as the return state and next state is FREEZE.
REQ-020 FREEZE: outputs as REQ-019 while the wait persists; the first cycle without a wait uses the outputs of the return state and moves to it.
REQ-021 StallCycles SHALL increment by 1 every cycle with Flush=1 or Freeze=1, and saturate at all-ones.
REQ-022 Total load-use bubbles SHALL equal LOAD_USE_STALLS exactly, independent of intervening freezes.

Reset
REQ-023 While Reset=0: state RUN, counter 0, return state RUN, StallCycles 0, PC_WriteEnable=0, IFID_WriteEnable=0, Flush=1, Freeze=0.
REQ-024 Reset assertion mid-STALL or mid-FREEZE SHALL abort the operation immediately; the first cycle after release is evaluated as RUN.

Structure
REQ-025 A shared package SHALL hold the state enum (RUN, STALL, FREEZE) and the default parameter constants.
REQ-026 Operand comparison (REQ-011) SHALL be one sub-module, hazard_reg_match, instantiated per comparison.

Verification
REQ-027 EX_MemRead=1, EX_RegWrite=1, EX_Rd=8, ID_Rs=8, ID_UsesRs=1, LOAD_USE_STALLS=2 -> Flush=1 and PC_WriteEnable=0 for exactly 2 cycles, StallCycles=2.
REQ-028 Same as REQ-027 but EX_Rd=0 and ID_Rs=0 -> no stall, PC_WriteEnable stays 1.
REQ-029 ID_IsBranch=1, ID_Rt=9, ID_UsesRt=1, EX_MemRead=1, EX_RegWrite=1, EX_Rd=9 -> 2 bubble cycles; with BRANCH_IN_ID=0 -> LOAD_USE_STALLS bubbles only.
REQ-030 Load-use stall (L=3) with DMem_Ready=0 for 4 cycles beginning in stall cycle 2 -> Freeze=1 for 4 cycles, then 2 further Flush cycles, StallCycles=7.
REQ-031 Reset driven low during STALL -> outputs reach reset values immediately; after release with no hazard, PC_WriteEnable=1 in the first cycle.
REQ-032 Hold Freeze continuously with CNT_W=4 for 20 cycles -> StallCycles=15 and it stays at 15.

Source files
------------

// File: rtl/hazard_stall_controller_pkg.sv
// rtl/hazard_stall_controller_pkg.sv - shared types and defaults for the hazard stall controller
// Holds the FSM state encoding and default parameter values used by the top and its helpers.
package hazard_stall_controller_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FREEZE = 2'd2
  } state_e;

  localparam int DEF_REG_ADDR_W      = 5;
  localparam int DEF_LOAD_USE_STALLS = 1;
  localparam int DEF_BRANCH_IN_ID    = 1;
  localparam int DEF_CNT_W           = 32;

  function automatic logic [1:0] max_len(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_reg_match.sv
// rtl/hazard_reg_match.sv - single source/destination register specifier comparison
// Register 0 is hardwired and therefore never produces a dependency.
module hazard_reg_match
  import hazard_stall_controller_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  uses,
  input  logic [REG_ADDR_W-1:0] dst,
  output logic                  match
);

  assign match = uses && (src != '0) && (src == dst);

endmodule

// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - load-use / branch hazard stall and memory-wait freeze control
// Hazard outputs are combinational in the detecting cycle; the FSM tracks remaining bubbles.
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int REG_ADDR_W      = DEF_REG_ADDR_W,
  parameter int LOAD_USE_STALLS = DEF_LOAD_USE_STALLS,
  parameter int BRANCH_IN_ID    = DEF_BRANCH_IN_ID,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [REG_ADDR_W-1:0] ID_Rs,
  input  logic [REG_ADDR_W-1:0] ID_Rt,
  input  logic                  ID_UsesRs,
  input  logic                  ID_UsesRt,
  input  logic                  ID_IsBranch,
  input  logic                  EX_MemRead,
  input  logic                  EX_RegWrite,
  input  logic [REG_ADDR_W-1:0] EX_Rd,
  input  logic                  MEM_MemRead,
  input  logic                  MEM_MemWrite,
  input  logic                  MEM_RegWrite,
  input  logic [REG_ADDR_W-1:0] MEM_Rd,
  input  logic                  DMem_Ready,
  output logic                  PC_WriteEnable,
  output logic                  IFID_WriteEnable,
  output logic                  Flush,
  output logic                  Freeze,
  output logic [CNT_W-1:0]      StallCycles
);

  localparam logic [1:0] LU_LEN = 2'(LOAD_USE_STALLS);
  localparam logic       BR_EN  = (BRANCH_IN_ID != 0);

  logic m_ex_rs, m_ex_rt, m_mem_rs, m_mem_rt;

  hazard_reg_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_ex_rs (
    .src(ID_Rs), .uses(ID_UsesRs), .dst(EX_Rd), .match(m_ex_rs)
  );
  hazard_reg_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_ex_rt (
    .src(ID_Rt), .uses(ID_UsesRt), .dst(EX_Rd), .match(m_ex_rt)
  );
  hazard_reg_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_mem_rs (
    .src(ID_Rs), .uses(ID_UsesRs), .dst(MEM_Rd), .match(m_mem_rs)
  );
  hazard_reg_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_mem_rt (
    .src(ID_Rt), .uses(ID_UsesRt), .dst(MEM_Rd), .match(m_mem_rt)
  );

  logic       ex_any, mem_any, load_use, mem_wait;
  logic [1:0] lu_len, br_len, haz_len;

  always_comb begin
    ex_any   = m_ex_rs | m_ex_rt;
    mem_any  = m_mem_rs | m_mem_rt;
    load_use = EX_MemRead & EX_RegWrite & ex_any;
    mem_wait = (MEM_MemRead | MEM_MemWrite) & ~DMem_Ready;
    lu_len   = load_use ? LU_LEN : 2'd0;
    br_len   = 2'd0;
    if (BR_EN && ID_IsBranch) begin
      if (EX_RegWrite && ex_any) begin
        br_len = EX_MemRead ? 2'd2 : 2'd1;
      end else if (MEM_MemRead && MEM_RegWrite && mem_any) begin
        br_len = 2'd1;
      end
    end
    haz_len = max_len(lu_len, br_len);
  end

  state_e           state_q, state_d, eff_state;
  logic [1:0]       cnt_q, cnt_d;
  logic             ret_q, ret_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    ret_d            = ret_q;
    PC_WriteEnable   = 1'b1;
    IFID_WriteEnable = 1'b1;
    Flush            = 1'b0;
    Freeze           = 1'b0;
    // Once a freeze clears, the cycle behaves exactly like the state it interrupted.
    eff_state        = state_q;
    if (state_q == FREEZE) begin
      eff_state = ret_q ? STALL : RUN;
    end

    if (mem_wait) begin
      Freeze           = 1'b1;
      PC_WriteEnable   = 1'b0;
      IFID_WriteEnable = 1'b0;
      if (state_q != FREEZE) begin
        ret_d   = (state_q == STALL);
        state_d = FREEZE;
      end
    end else begin
      case (eff_state)
        STALL: begin
          PC_WriteEnable   = 1'b0;
          IFID_WriteEnable = 1'b0;
          Flush            = 1'b1;
          if (cnt_q == 2'd0) begin
            state_d = RUN;
          end else begin
            cnt_d   = cnt_q - 2'd1;
            state_d = STALL;
          end
        end
        default: begin
          state_d = RUN;
          if (haz_len != 2'd0) begin
            PC_WriteEnable   = 1'b0;
            IFID_WriteEnable = 1'b0;
            Flush            = 1'b1;
            if (haz_len > 2'd1) begin
              state_d = STALL;
              cnt_d   = haz_len - 2'd2;
            end
          end
        end
      endcase
    end

    if (!Reset) begin
      PC_WriteEnable   = 1'b0;
      IFID_WriteEnable = 1'b0;
      Flush            = 1'b1;
      Freeze           = 1'b0;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if ((Flush || Freeze) && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
      ret_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ret_q   <= ret_d;
      stall_q <= stall_d;
    end
  end

  assign StallCycles = stall_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - directed self-checking bench for hazard_stall_controller
// Four parameterisations share one stimulus bus so each scenario exercises several configurations.
module tb_hazard_stall_controller;

  logic       Clock, Reset;
  logic [4:0] ID_Rs, ID_Rt, EX_Rd, MEM_Rd;
  logic       ID_UsesRs, ID_UsesRt, ID_IsBranch;
  logic       EX_MemRead, EX_RegWrite;
  logic       MEM_MemRead, MEM_MemWrite, MEM_RegWrite, DMem_Ready;

  logic        l2_pc, l2_ifid, l2_flush, l2_freeze;
  logic [31:0] l2_cnt;
  logic        l3_pc, l3_ifid, l3_flush, l3_freeze;
  logic [31:0] l3_cnt;
  logic        nb_pc, nb_ifid, nb_flush, nb_freeze;
  logic [31:0] nb_cnt;
  logic        c4_pc, c4_ifid, c4_flush, c4_freeze;
  logic [3:0]  c4_cnt;

  int checks = 0;
  int errors = 0;

  hazard_stall_controller #(.LOAD_USE_STALLS(2)) u_l2 (
    .Clock(Clock), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_IsBranch(ID_IsBranch),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_Rd(EX_Rd),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .MEM_RegWrite(MEM_RegWrite),
    .MEM_Rd(MEM_Rd), .DMem_Ready(DMem_Ready),
    .PC_WriteEnable(l2_pc), .IFID_WriteEnable(l2_ifid), .Flush(l2_flush),
    .Freeze(l2_freeze), .StallCycles(l2_cnt)
  );

  hazard_stall_controller #(.LOAD_USE_STALLS(3)) u_l3 (
    .Clock(Clock), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_IsBranch(ID_IsBranch),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_Rd(EX_Rd),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .MEM_RegWrite(MEM_RegWrite),
    .MEM_Rd(MEM_Rd), .DMem_Ready(DMem_Ready),
    .PC_WriteEnable(l3_pc), .IFID_WriteEnable(l3_ifid), .Flush(l3_flush),
    .Freeze(l3_freeze), .StallCycles(l3_cnt)
  );

  hazard_stall_controller #(.LOAD_USE_STALLS(1), .BRANCH_IN_ID(0)) u_nb (
    .Clock(Clock), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_IsBranch(ID_IsBranch),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_Rd(EX_Rd),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .MEM_RegWrite(MEM_RegWrite),
    .MEM_Rd(MEM_Rd), .DMem_Ready(DMem_Ready),
    .PC_WriteEnable(nb_pc), .IFID_WriteEnable(nb_ifid), .Flush(nb_flush),
    .Freeze(nb_freeze), .StallCycles(nb_cnt)
  );

  hazard_stall_controller #(.LOAD_USE_STALLS(1), .CNT_W(4)) u_c4 (
    .Clock(Clock), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_IsBranch(ID_IsBranch),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_Rd(EX_Rd),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .MEM_RegWrite(MEM_RegWrite),
    .MEM_Rd(MEM_Rd), .DMem_Ready(DMem_Ready),
    .PC_WriteEnable(c4_pc), .IFID_WriteEnable(c4_ifid), .Flush(c4_flush),
    .Freeze(c4_freeze), .StallCycles(c4_cnt)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic clear_inputs();
    ID_Rs = 5'd0; ID_Rt = 5'd0; EX_Rd = 5'd0; MEM_Rd = 5'd0;
    ID_UsesRs = 1'b0; ID_UsesRt = 1'b0; ID_IsBranch = 1'b0;
    EX_MemRead = 1'b0; EX_RegWrite = 1'b0;
    MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; MEM_RegWrite = 1'b0;
    DMem_Ready = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge Clock);
    clear_inputs();
    Reset = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  task automatic drive_load_use();
    EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_Rd = 5'd8;
    ID_Rs = 5'd8; ID_UsesRs = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge Clock);
    clear_inputs();
    Reset = 1'b0;
    #1;
    checks++;
    if ({l2_pc, l2_ifid, l2_flush, l2_freeze} !== 4'b0010) begin
      errors++;
      $display("FAIL reset_outputs: got pc/ifid/flush/freeze=%b expected 0010",
               {l2_pc, l2_ifid, l2_flush, l2_freeze});
    end
    checks++;
    if (l2_cnt !== 32'd0 || c4_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d/%0d expected 0/0", l2_cnt, c4_cnt);
    end
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    checks++;
    if ({l2_pc, l2_ifid, l2_flush, l2_freeze} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_release_run: got pc/ifid/flush/freeze=%b expected 1100",
               {l2_pc, l2_ifid, l2_flush, l2_freeze});
    end
  endtask

  task automatic test_load_use();
    logic [4:0] exp_l2, exp_l3, exp_nb;
    exp_l2 = 5'b00011;
    exp_l3 = 5'b00111;
    exp_nb = 5'b00001;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge Clock);
      clear_inputs();
      if (c == 0) drive_load_use();
      #1;
      checks++;
      if (l2_flush !== exp_l2[c] || l2_pc !== ~exp_l2[c] || l2_ifid !== ~exp_l2[c]) begin
        errors++;
        $display("FAIL load_use_l2 cycle %0d: got flush=%b pc=%b expected flush=%b pc=%b",
                 c, l2_flush, l2_pc, exp_l2[c], ~exp_l2[c]);
      end
      checks++;
      if (l3_flush !== exp_l3[c] || nb_flush !== exp_nb[c]) begin
        errors++;
        $display("FAIL load_use_l3_l1 cycle %0d: got flush=%b/%b expected %b/%b",
                 c, l3_flush, nb_flush, exp_l3[c], exp_nb[c]);
      end
    end
    checks++;
    if (l2_cnt !== 32'd2 || l3_cnt !== 32'd3 || nb_cnt !== 32'd1) begin
      errors++;
      $display("FAIL load_use_count: got %0d/%0d/%0d expected 2/3/1", l2_cnt, l3_cnt, nb_cnt);
    end
  endtask

  task automatic test_reg_zero();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge Clock);
      EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_Rd = 5'd0;
      ID_Rs = 5'd0; ID_UsesRs = 1'b1;
      #1;
      checks++;
      if (l2_pc !== 1'b1 || l2_flush !== 1'b0 || l3_pc !== 1'b1) begin
        errors++;
        $display("FAIL reg_zero cycle %0d: got pc=%b flush=%b expected pc=1 flush=0",
                 c, l2_pc, l2_flush);
      end
    end
    @(negedge Clock);
    clear_inputs();
    checks++;
    if (l2_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reg_zero_count: got %0d expected 0", l2_cnt);
    end
  endtask

  task automatic test_branch();
    logic [3:0] exp_c4, exp_nb, exp_l2;
    logic [3:0] bub_c4;
    for (int s = 0; s < 4; s++) begin
      case (s)
        0: begin exp_c4 = 4'b0011; exp_nb = 4'b0001; exp_l2 = 4'b0011; bub_c4 = 4'd2; end
        1: begin exp_c4 = 4'b0001; exp_nb = 4'b0000; exp_l2 = 4'b0001; bub_c4 = 4'd1; end
        2: begin exp_c4 = 4'b0001; exp_nb = 4'b0000; exp_l2 = 4'b0001; bub_c4 = 4'd1; end
        default: begin exp_c4 = 4'b0000; exp_nb = 4'b0000; exp_l2 = 4'b0000; bub_c4 = 4'd0; end
      endcase
      do_reset();
      for (int c = 0; c < 4; c++) begin
        @(negedge Clock);
        clear_inputs();
        if (c == 0) begin
          case (s)
            0: begin
              ID_IsBranch = 1'b1; ID_Rt = 5'd9; ID_UsesRt = 1'b1;
              EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_Rd = 5'd9;
            end
            1: begin
              ID_IsBranch = 1'b1; ID_Rs = 5'd5; ID_UsesRs = 1'b1;
              EX_RegWrite = 1'b1; EX_Rd = 5'd5;
            end
            2: begin
              ID_IsBranch = 1'b1; ID_Rs = 5'd5; ID_UsesRs = 1'b1;
              MEM_MemRead = 1'b1; MEM_RegWrite = 1'b1; MEM_Rd = 5'd5;
            end
            default: begin
              ID_Rs = 5'd5; ID_UsesRs = 1'b1;
              MEM_MemRead = 1'b1; MEM_RegWrite = 1'b1; MEM_Rd = 5'd5;
            end
          endcase
        end
        #1;
        checks++;
        if (c4_flush !== exp_c4[c] || nb_flush !== exp_nb[c] || l2_flush !== exp_l2[c]) begin
          errors++;
          $display("FAIL branch s%0d cycle %0d: got flush br/nobr/l2=%b%b%b expected %b%b%b",
                   s, c, c4_flush, nb_flush, l2_flush, exp_c4[c], exp_nb[c], exp_l2[c]);
        end
      end
      checks++;
      if (c4_cnt !== bub_c4) begin
        errors++;
        $display("FAIL branch_count s%0d: got %0d expected %0d", s, c4_cnt, bub_c4);
      end
    end
  endtask

  task automatic test_freeze_in_stall();
    logic [8:0] exp_flush, exp_freeze;
    exp_flush  = 9'b001100001;
    exp_freeze = 9'b000011110;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      @(negedge Clock);
      clear_inputs();
      if (c == 0) drive_load_use();
      if (c >= 1 && c <= 4) begin
        MEM_MemRead = 1'b1;
        DMem_Ready  = 1'b0;
      end
      #1;
      checks++;
      if (l3_flush !== exp_flush[c] || l3_freeze !== exp_freeze[c] ||
          l3_pc !== ~(exp_flush[c] | exp_freeze[c])) begin
        errors++;
        $display("FAIL freeze_stall cycle %0d: got flush=%b freeze=%b pc=%b expected %b %b %b",
                 c, l3_flush, l3_freeze, l3_pc, exp_flush[c], exp_freeze[c],
                 ~(exp_flush[c] | exp_freeze[c]));
      end
    end
    checks++;
    if (l3_cnt !== 32'd7 || l2_cnt !== 32'd6) begin
      errors++;
      $display("FAIL freeze_stall_count: got %0d/%0d expected 7/6", l3_cnt, l2_cnt);
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    @(negedge Clock);
    clear_inputs();
    drive_load_use();
    @(negedge Clock);
    clear_inputs();
    #1;
    checks++;
    if (l3_flush !== 1'b1) begin
      errors++;
      $display("FAIL mid_stall_pre: got flush=%b expected 1", l3_flush);
    end
    #1 Reset = 1'b0;
    #1;
    checks++;
    if ({l3_pc, l3_ifid, l3_flush, l3_freeze} !== 4'b0010 || l3_cnt !== 32'd0) begin
      errors++;
      $display("FAIL mid_stall_reset: got outs=%b cnt=%0d expected 0010 cnt=0",
               {l3_pc, l3_ifid, l3_flush, l3_freeze}, l3_cnt);
    end
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    checks++;
    if (l3_pc !== 1'b1 || l3_flush !== 1'b0) begin
      errors++;
      $display("FAIL mid_stall_release: got pc=%b flush=%b expected 1 0", l3_pc, l3_flush);
    end

    @(negedge Clock);
    drive_load_use();
    @(negedge Clock);
    clear_inputs();
    MEM_MemRead = 1'b1;
    DMem_Ready  = 1'b0;
    #1;
    checks++;
    if (l3_freeze !== 1'b1) begin
      errors++;
      $display("FAIL mid_freeze_pre: got freeze=%b expected 1", l3_freeze);
    end
    #1 Reset = 1'b0;
    #1;
    checks++;
    if (l3_freeze !== 1'b0 || l3_flush !== 1'b1 || l3_pc !== 1'b0) begin
      errors++;
      $display("FAIL mid_freeze_reset: got freeze=%b flush=%b pc=%b expected 0 1 0",
               l3_freeze, l3_flush, l3_pc);
    end
    @(negedge Clock);
    clear_inputs();
    Reset = 1'b1;
    #1;
    checks++;
    if (l3_pc !== 1'b1 || l3_flush !== 1'b0 || l3_freeze !== 1'b0) begin
      errors++;
      $display("FAIL mid_freeze_release: got pc=%b flush=%b freeze=%b expected 1 0 0",
               l3_pc, l3_flush, l3_freeze);
    end
  endtask

  task automatic test_saturation();
    logic [3:0] exp_cnt;
    do_reset();
    for (int c = 0; c < 23; c++) begin
      @(negedge Clock);
      MEM_MemWrite = 1'b1;
      DMem_Ready   = 1'b0;
      #1;
      exp_cnt = (c < 15) ? 4'(c) : 4'd15;
      checks++;
      if (c4_freeze !== 1'b1 || c4_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL saturate cycle %0d: got freeze=%b cnt=%0d expected 1 %0d",
                 c, c4_freeze, c4_cnt, exp_cnt);
      end
    end
    @(negedge Clock);
    clear_inputs();
    #1;
    checks++;
    if (c4_cnt !== 4'd15 || c4_freeze !== 1'b0 || c4_pc !== 1'b1) begin
      errors++;
      $display("FAIL saturate_end: got cnt=%0d freeze=%b pc=%b expected 15 0 1",
               c4_cnt, c4_freeze, c4_pc);
    end
  endtask

  initial begin
    Reset = 1'b0;
    clear_inputs();
    test_reset();
    test_load_use();
    test_reg_zero();
    test_branch();
    test_freeze_in_stall();
    test_reset_mid_op();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
